// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared constants for the reg_file_sb register file.
// Optional same-cycle bypass is selected with the RF_BYPASS_EN macro.
package reg_file_sb_pkg;
  localparam bit ENABLE   = 1'b1;
  localparam bit DISABLE  = 1'b0;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int RF_AW    = $clog2(NREG_DEF);
  localparam int R0_ADDR  = 0;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - per-register busy bits and registered busy count.
// Priority per edge: flush clears all, else issue sets over writeback clear.
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      wr_en,
  input  logic [2*AW-1:0] wr_addr,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   busy_cnt
);
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt_nxt;

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
      end
      // A new producer issued this cycle supersedes the one retiring.
      if (iss_en) busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[R0_ADDR] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = R0_ADDR + 1; r < NREG; r++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read, dual-write register file with busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data and busy clears to readers.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRD*AW-1:0]         rd_addr_bus,
  output logic [NRD*XLEN-1:0]       rd_data_bus,
  output logic [NRD-1:0]            rd_busy,
  input  logic [1:0]                wr_en,
  input  logic [2*AW-1:0]           wr_addr,
  input  logic [2*XLEN-1:0]         wr_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_rd,
  input  logic                      flush,
  output logic [$clog2(NREG+1)-1:0] busy_cnt
);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      // Lane 1 is applied last so it wins a same-address collision.
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_addr[k*AW +: AW] != AW'(R0_ADDR))
          mem[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .CW   (CW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr_bus[i*AW +: AW];

    always_comb begin
      data = mem[addr];
      bsy  = busy[addr];
`ifdef RF_BYPASS_EN
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_addr[k*AW +: AW] == addr) begin
          data = wr_data[k*XLEN +: XLEN];
          bsy  = 1'b0;
        end
      end
`endif
      if (addr == AW'(R0_ADDR)) data = '0;
    end

    assign rd_data_bus[i*XLEN +: XLEN] = data;
    assign rd_busy[i]                  = bsy;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and random checks of reg_file_sb against a behavioural model.
// Expectations follow RF_BYPASS_EN when the macro is defined for the build.
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr_bus = '0;
  logic [NRD*XLEN-1:0] rd_data_bus;
  logic [NRD-1:0]      rd_busy;
  logic [1:0]          wr_en = '0;
  logic [2*AW-1:0]     wr_addr = '0;
  logic [2*XLEN-1:0]   wr_data = '0;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_rd = '0;
  logic                flush = 1'b0;
  logic [CW-1:0]       busy_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr_bus (rd_addr_bus),
    .rd_data_bus (rd_data_bus),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .iss_en      (iss_en),
    .iss_rd      (iss_rd),
    .flush       (flush),
    .busy_cnt    (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a);
    logic [XLEN-1:0] v;
    v = m_reg[a];
`ifdef RF_BYPASS_EN
    if (wr_en[0] && int'(wr_addr[0 +: AW]) == a) v = wr_data[0 +: XLEN];
    if (wr_en[1] && int'(wr_addr[AW +: AW]) == a) v = wr_data[XLEN +: XLEN];
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    bit b;
    b = m_busy[a];
`ifdef RF_BYPASS_EN
    if (wr_en[0] && int'(wr_addr[0 +: AW]) == a) b = 1'b0;
    if (wr_en[1] && int'(wr_addr[AW +: AW]) == a) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic check_reads(input string tag);
    for (int p = 0; p < NRD; p++) begin
      int a;
      a = int'(rd_addr_bus[p*AW +: AW]);
      check({tag, "_data"}, 64'(rd_data_bus[p*XLEN +: XLEN]), 64'(exp_data(a)));
      check({tag, "_busy"}, 64'(rd_busy[p]), 64'(exp_busy(a)));
    end
  endtask

  // Inputs are set in the low clock phase; one call covers one full clock.
  task automatic cycle(input string tag);
    #1;
    check_reads(tag);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(wr_addr[k*AW +: AW]);
      if (wr_en[k] && a != 0) m_reg[a] = wr_data[k*XLEN +: XLEN];
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) if (wr_en[k]) m_busy[int'(wr_addr[k*AW +: AW])] = 1'b0;
      if (iss_en && iss_rd != '0) m_busy[int'(iss_rd)] = 1'b1;
    end
    @(negedge clk);
    check({tag, "_cnt"}, 64'(busy_cnt), 64'(model_cnt()));
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check("rst_data0", 64'(rd_data_bus[0 +: XLEN]), 64'h0);
    check("rst_cnt", 64'(busy_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset after r5 is written and r6 issued.
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: XLEN] = 32'hDEADBEEF;
    iss_en = 1'b1; iss_rd = 5'd6;
    rd_addr_bus = {5'd6, 5'd5};
    cycle("wr_r5");
    #1;
    check("r5_stored", 64'(rd_data_bus[0 +: XLEN]), 64'hDEADBEEF);
    check("r6_busy", 64'(rd_busy[1]), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_data", 64'(rd_data_bus[0 +: XLEN]), 64'h0);
    check("arst_busy", 64'(rd_busy), 64'h0);
    check("arst_cnt", 64'(busy_cnt), 64'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Register 0 ignores writes and issues.
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: XLEN] = 32'h12345678;
    iss_en = 1'b1; iss_rd = 5'd0;
    rd_addr_bus = {5'd0, 5'd0};
    cycle("r0");
    #1;
    check("r0_data", 64'(rd_data_bus[0 +: XLEN]), 64'h0);
    check("r0_busy", 64'(rd_busy[0]), 64'h0);
    check("r0_cnt", 64'(busy_cnt), 64'h0);

    // Dual-lane collision on r7, lane 1 wins.
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd7; wr_data[0 +: XLEN] = 32'h77;
    cycle("r7_init");
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111};
    rd_addr_bus = {5'd0, 5'd7};
    #1;
`ifdef RF_BYPASS_EN
    check("r7_same", 64'(rd_data_bus[0 +: XLEN]), 64'h2222);
`else
    check("r7_same", 64'(rd_data_bus[0 +: XLEN]), 64'h77);
`endif
    cycle("r7_both");
    #1;
    check("r7_next", 64'(rd_data_bus[0 +: XLEN]), 64'h2222);

    // Issue r3, then writeback r3.
    iss_en = 1'b1; iss_rd = 5'd3;
    cycle("iss_r3");
    rd_addr_bus = {5'd0, 5'd3};
    #1;
    check("r3_busy", 64'(rd_busy[0]), 64'h1);
    check("r3_cnt", 64'(busy_cnt), 64'h1);
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = 32'hA5;
    #1;
`ifdef RF_BYPASS_EN
    check("r3_wb_busy", 64'(rd_busy[0]), 64'h0);
    check("r3_wb_data", 64'(rd_data_bus[0 +: XLEN]), 64'hA5);
`else
    check("r3_wb_busy", 64'(rd_busy[0]), 64'h1);
    check("r3_wb_data", 64'(rd_data_bus[0 +: XLEN]), 64'h0);
`endif
    cycle("wb_r3");
    check("r3_cnt_clr", 64'(busy_cnt), 64'h0);

    // Same-cycle issue and write to r9: set wins.
    iss_en = 1'b1; iss_rd = 5'd9;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd9; wr_data[0 +: XLEN] = 32'h55;
    cycle("iss_wr_r9");
    rd_addr_bus = {5'd0, 5'd9};
    #1;
    check("r9_data", 64'(rd_data_bus[0 +: XLEN]), 64'h55);
    check("r9_busy", 64'(rd_busy[0]), 64'h1);
    check("r9_cnt", 64'(busy_cnt), 64'h1);

    // Fill the scoreboard, then flush over a concurrent issue.
    for (int r = 1; r < NREG; r++) begin
      iss_en = 1'b1; iss_rd = AW'(r);
      cycle("fill");
    end
    check("full_cnt", 64'(busy_cnt), 64'd31);
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd4;
    rd_addr_bus = {5'd9, 5'd4};
    cycle("flush");
    check("flush_cnt", 64'(busy_cnt), 64'h0);
    #1;
    check("flush_r4", 64'(rd_busy), 64'h0);

    // Random traffic with narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      wr_en  = 2'($urandom_range(0, 3));
      wr_addr = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      wr_data = {32'($urandom), 32'($urandom)};
      iss_en = 1'($urandom_range(0, 1));
      iss_rd = AW'($urandom_range(0, 11));
      flush  = ($urandom_range(0, 19) == 0);
      rd_addr_bus = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor register file for the dCPU core.
- Features: N read ports, two write ports, all entries reset, same-cycle write-to-read bypass, and a per-register busy scoreboard for in-flight producers.
- Sits between decode (reads, issue) and writeback (two retire lanes).
- Lets decode stall on RAW hazards without separate hazard logic.

Parameters:
XLEN  32  data width in bits
NREG  32  number of architectural registers (power of 2, >=2)
NRD  2  number of read ports (1..4)
AW  $clog2(NREG)  address width; derived, do not override

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous reset, active-low
rd_addr_bus  input  NRD*AW  read addresses; port i = bits [i*AW +: AW]
rd_data_bus  output  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN]
rd_busy  output  NRD  port i source has a pending producer
wr_en  input  2  write enables, lanes 0/1
wr_addr  input  2*AW  write addresses, lane k = bits [k*AW +: AW]
wr_data  input  2*XLEN  write data, lane k = bits [k*XLEN +: XLEN]
iss_en  input  1  an instruction issues with destination iss_rd
iss_rd  input  AW  destination register of the issuing instruction
flush  input  1  synchronous clear of all busy bits (pipeline flush)
busy_cnt  output  $clog2(NREG+1)  number of registers currently marked busy

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all NREG entries = 0, all busy bits = 0, busy_cnt = 0.
  - Takes effect mid-cycle regardless of clk; any in-flight write or issue that cycle is lost.
- Register 0:
  - Reads always return 0 and busy always reads 0.
  - Writes and issues targeting address 0 are ignored.
- Writes:
  - Update on posedge clk when wr_en[k] = 1 and wr_addr != 0.
  - Both lanes to the same nonzero address: lane 1 wins.
- Reads:
  - Combinational, zero-latency.
  - With bypass (see Optional Feature): a same-cycle write to the read address returns wr_data (lane 1 priority).
- Scoreboard, applied per register at posedge:
  - Write clears busy; issue sets busy.
  - Issue and write to the same register in one cycle: set wins, busy = 1 next cycle (new producer supersedes).
  - flush = 1: all busy bits = 0, overriding any issue that cycle. Writes still land.
- rd_busy[i] = busy[addr] & ~(same-cycle write clearing addr), i.e. a producer writing back this cycle no longer stalls the reader.
  - Without bypass, the clear-forwarding term is removed.
- busy_cnt:
  - Registered.
  - Equals the population count of busy bits after each edge.
  - Never exceeds NREG-1, since register 0 is never busy.
- Redundant events:
  - Issue to an already-busy register: stays busy, count unchanged.
  - Write to a non-busy register: data updates, count unchanged.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Same-cycle write data is forwarded to read ports.
  - rd_busy masks same-cycle clears.
- Undefined:
  - Reads return stored value only; new data is visible the cycle after the write.
  - rd_busy reflects stored busy bits only.
  - Saves the read-port mux tree for FPGA timing.

Decomposition:
- Shared package/header (alongside existing ENABLE/DISABLE defines):
  - XLEN and NREG defaults.
  - Register-address width constant.
  - Register-0 address constant.
- Sub-module rf_scoreboard:
  - Owns busy bits, set/clear/flush priority and busy_cnt.
  - Instantiated once.
  - Data array and read/bypass muxing stay in reg_file_sb.

Test Plan:
- Reset with rst_n pulsed mid-cycle after writes to r5 = 0xDEADBEEF -> all rd_data 0, rd_busy 0, busy_cnt 0 immediately, without waiting for a clock edge.
- Write r0 = 0x12345678 and issue r0 -> reading r0 returns 0, rd_busy 0, busy_cnt stays 0.
- Both lanes write r7 (lane0 0x1111, lane1 0x2222) same cycle, port0 reads r7:
  - With bypass: 0x2222 that cycle, 0x2222 next.
  - Without bypass: old value that cycle, then 0x2222.
- Issue r3, next cycle read r3 -> rd_busy[0] = 1, busy_cnt 1. Writeback r3 = 0xA5 -> with bypass rd_busy 0 and data 0xA5 that cycle; busy_cnt 0 next cycle.
- Same-cycle issue r9 and lane0 write r9 = 0x55 -> r9 = 0x55 stored, busy[r9] = 1 after the edge, busy_cnt +1.
- Issue r1..r31 on consecutive cycles -> busy_cnt reaches 31. Then flush together with issue r4 -> all busy 0, busy_cnt 0 next cycle.
